// File: rtl/jig_loop_checker.sv
// Pin-chain self-test engine for the pico-ice test jig: drives a set of patterns onto the
// output pins, samples the looped-back inputs and collects a per-pin error mask and count.
module jig_loop_checker #(
   parameter int unsigned WIDTH         = 17,
   parameter int unsigned SETTLE_CYCLES = 16,
   parameter int unsigned SYNC_STAGES   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] pins_i,
   output logic [WIDTH-1:0] pins_o,
   output logic             pins_oe,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [WIDTH-1:0] err_mask,
   output logic [7:0]       err_count
);

   localparam int unsigned NumPat = 2 * WIDTH + 2;
   localparam int unsigned IdxW   = $clog2(NumPat);
   localparam int unsigned CntW   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   localparam logic [IdxW-1:0] LastIdx = IdxW'(NumPat - 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

   state_e            state_q;
   logic [IdxW-1:0]   idx_q;
   logic [CntW-1:0]   cnt_q;
   logic [WIDTH-1:0]  sync_q [SYNC_STAGES];
   logic [WIDTH-1:0]  sync_in;
   logic [WIDTH-1:0]  diff;
   logic [WIDTH-1:0]  mask_n;

   // Walking one, walking zero, then all zeros and all ones.
   function automatic logic [WIDTH-1:0] pattern(input logic [IdxW-1:0] i);
      logic [WIDTH-1:0] one;
      logic [WIDTH-1:0] p;
      one = WIDTH'(1);
      if (i < IdxW'(WIDTH))          p = one << i;
      else if (i < IdxW'(2 * WIDTH)) p = ~(one << (i - IdxW'(WIDTH)));
      else if (i == IdxW'(2 * WIDTH)) p = '0;
      else                           p = '1;
      return p;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      end else begin
         sync_q[0] <= pins_i;
         for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   assign sync_in = sync_q[SYNC_STAGES-1];
   assign diff    = sync_in ^ pins_o;
   assign mask_n  = err_mask | diff;

   always_ff @(posedge clk) begin
      if (rst || abort) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         cnt_q     <= '0;
         pins_o    <= '0;
         pins_oe   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_mask  <= '0;
         err_count <= '0;
      end else begin
         unique case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  err_mask  <= '0;
                  err_count <= '0;
                  done      <= 1'b0;
                  pass      <= 1'b0;
                  idx_q     <= '0;
                  pins_o    <= pattern('0);
                  pins_oe   <= 1'b1;
                  cnt_q     <= '0;
                  busy      <= 1'b1;
                  state_q   <= StSettle;
               end
            end
            StSettle: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LastCnt) state_q <= StSample;
            end
            StSample: begin
               err_mask <= mask_n;
               if ((diff != '0) && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
               if (idx_q == LastIdx) begin
                  state_q <= StDone;
                  pins_oe <= 1'b0;
                  pins_o  <= '0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  pass    <= (mask_n == '0);
               end else begin
                  idx_q   <= idx_q + 1'b1;
                  pins_o  <= pattern(idx_q + 1'b1);
                  cnt_q   <= '0;
                  state_q <= StSettle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_jig_loop_checker.sv
// Self-checking bench for jig_loop_checker: table of loopback fault scenarios checked through
// a scoreboard queue, plus hand-written abort, restart and reset sequences.
module tb_jig_loop_checker;

   localparam int RunLat = 36 * 17;

   logic        clk = 1'b0;
   logic        rst, start, abort;
   logic [16:0] pins_i, pins_o, err_mask, rnd;
   logic        pins_oe, busy, done, pass;
   logic [7:0]  err_count;
   logic [2:0]  mode;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      string       name;
      logic [2:0]  mode;
      logic [16:0] mask;
      logic [7:0]  count;
      logic        pass;
   } vec_t;

   vec_t exp_q[$];
   vec_t vecs[4];

   jig_loop_checker dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .pins_i    (pins_i),
      .pins_o    (pins_o),
      .pins_oe   (pins_oe),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .err_mask  (err_mask),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   // Loopback with an injectable fault: 1 = bit5 stuck-0, 2 = bits 2/3 wired-AND,
   // 3 = bit0 stuck-1, 4 = free-running random inputs.
   always_comb begin
      pins_i = pins_o;
      case (mode)
         3'd1: pins_i[5] = 1'b0;
         3'd2: begin
            pins_i[2] = pins_o[2] & pins_o[3];
            pins_i[3] = pins_o[2] & pins_o[3];
         end
         3'd3: pins_i[0] = 1'b1;
         3'd4: pins_i = rnd;
         default: ;
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_pass"}, 32'(pass), 32'd0);
      check({tag, "_oe"}, 32'(pins_oe), 32'd0);
      check({tag, "_pins_o"}, 32'(pins_o), 32'd0);
      check({tag, "_mask"}, 32'(err_mask), 32'd0);
      check({tag, "_count"}, 32'(err_count), 32'd0);
   endtask

   // Waits for done with a cycle budget and returns the cycles since the start edge.
   task automatic wait_done(input int already, output int lat);
      lat = already;
      while (!done && lat < RunLat + 50) begin
         tick();
         lat++;
      end
   endtask

   task automatic score(input string tag, input int lat);
      vec_t e;
      check({tag, "_latency"}, 32'(lat), 32'(RunLat));
      if (exp_q.size() == 0) begin
         check({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_mask"}, 32'(err_mask), 32'(e.mask));
         check({tag, "_count"}, 32'(err_count), 32'(e.count));
         check({tag, "_pass"}, 32'(pass), 32'(e.pass));
      end
      check({tag, "_oe_off"}, 32'(pins_oe), 32'd0);
      check({tag, "_busy_off"}, 32'(busy), 32'd0);
   endtask

   task automatic run_vec(input vec_t v);
      int lat;
      mode  = v.mode;
      start = 1'b1;
      tick();
      start = 1'b0;
      exp_q.push_back(v);
      check({v.name, "_busy_on"}, 32'(busy), 32'd1);
      check({v.name, "_oe_on"}, 32'(pins_oe), 32'd1);
      wait_done(0, lat);
      score(v.name, lat);
   endtask

   initial begin
      int lat;
      vec_t ideal;

      vecs[0] = '{name: "ideal",    mode: 3'd0, mask: 17'h00000, count: 8'd0,  pass: 1'b1};
      vecs[1] = '{name: "stuck5_0", mode: 3'd1, mask: 17'h00020, count: 8'd18, pass: 1'b0};
      vecs[2] = '{name: "bridge23", mode: 3'd2, mask: 17'h0000C, count: 8'd4,  pass: 1'b0};
      vecs[3] = '{name: "stuck0_1", mode: 3'd3, mask: 17'h00001, count: 8'd18, pass: 1'b0};
      ideal = vecs[0];

      rst   = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      mode  = 3'd0;
      rnd   = '0;
      repeat (3) tick();
      check_idle("reset");
      rst = 1'b0;
      tick();

      for (int i = 0; i < 4; i++) run_vec(vecs[i]);

      // Abort partway through a failing run, then a clean run must pass.
      mode  = 3'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (100) tick();
      check("abort_pre_mask", 32'(err_mask), 32'h1);
      check("abort_pre_count", 32'(err_count), 32'd4);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_idle("abort");
      run_vec(ideal);

      // start pulses while busy are ignored.
      mode  = 3'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      exp_q.push_back(ideal);
      lat = 0;
      while (!done && lat < RunLat + 50) begin
         if (lat == 9 || lat == 299) start = 1'b1;
         tick();
         start = 1'b0;
         lat++;
      end
      score("restart_ignored", lat);

      start = 1'b1;
      tick();
      start = 1'b0;
      check("restart_done_clr", 32'(done), 32'd0);
      check("restart_busy", 32'(busy), 32'd1);

      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check_idle("start_abort");

      // Reset mid-settle with a fault present.
      mode  = 3'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (40) tick();
      check("rst_pre_mask", 32'(err_mask), 32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle("rst_mid");

      // Inputs toggling while idle must not disturb the status.
      mode = 3'd4;
      for (int c = 0; c < 20; c++) begin
         rnd = 17'($urandom);
         tick();
      end
      check_idle("idle_toggle");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
